i2c_slave: RTL
==============

Name: i2c_slave

Overview:
- I2C target (responder) that is the other end of the team's i2c_master.
- Oversamples SCL/SDA on the system clock, detects START, repeated START and STOP, and matches a fixed 7-bit address.
- Acknowledges writes and hands each received byte to user logic; on reads, shifts out bytes supplied by user logic.
- Standard-mode/fast-mode target with no clock stretching; used as the bus model/peripheral front end on the same bus as i2c_master.

Parameters:
- SLAVE_ADDR, 7'h2A, 7-bit bus address this target responds to.
- FILTER_LEN, 4, consecutive identical synchronized samples required before a line level change is accepted (glitch filter); range 1..15.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- scl  input  1  I2C clock line (target never drives SCL)
- sda  inout  1  I2C data line, open drain: driven 0 or released to z
- wr_tick  output  1  one-clk pulse: wr_data holds a byte written by the master
- wr_data  output  8  last byte received in a write transfer
- rd_req  output  1  one-clk pulse: user must present the next read byte on tx_data
- tx_data  input  8  read byte, sampled exactly one clk after rd_req
- busy  output  1  high while addressed (from address ACK until STOP, START, or NACK end)
- stop_tick  output  1  one-clk pulse on every detected STOP

Behaviour:
- Reset (asynchronous): sda released (z); wr_tick=0, rd_req=0, stop_tick=0, busy=0, wr_data=8'h00; FSM in IDLE; filters preset to 1 (idle bus).
- Each line passes a 2-flop synchronizer, then the FILTER_LEN filter. Edge detection latency is 2+FILTER_LEN clk from the pin.
- START: filtered SDA falls while filtered SCL is high. It is accepted from any state, which gives repeated START.
  - Action: enter ADDR, clear bit counter, release sda, busy=0.
- STOP: filtered SDA rises while filtered SCL is high. From any state, go to IDLE, release sda, busy=0, and pulse stop_tick for one clk.
- Data bits are sampled on filtered SCL rising edges, MSB first. Driven sda changes only on filtered SCL falling edges.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK, IGNORE.
- ADDR: shift 8 bits. After the 8th rising edge, compare bits[7:1] with SLAVE_ADDR.
  - Mismatch: go to IGNORE. sda stays released for the 9th bit (NACK).
  - Match: on the following SCL fall, drive sda=0 and go to ADDR_ACK. busy=1.
- ADDR_ACK: hold sda low through the 9th clock. On the 9th SCL fall:
  - R/W=0: release sda and go to WR_BYTE.
  - R/W=1: pulse rd_req and go to RD_LOAD.
- WR_BYTE: shift 8 bits. On the 8th rising edge, wr_data takes the shifted byte and wr_tick pulses in the same clk. On the next SCL fall, drive sda=0 and go to WR_ACK.
  - Every write byte is ACKed; there is no backpressure.
- WR_ACK: on the 9th SCL fall, release sda and go to WR_BYTE.
- RD_LOAD: lasts 1 clk after rd_req. Latch tx_data into the shift register, drive its MSB (drive 0 for bit=0, release for bit=1), go to RD_BYTE.
  - SCL is already low when the byte is loaded.
- RD_BYTE: on each SCL fall, present the next bit. After the 8th SCL fall, release sda and go to RD_ACK.
- RD_ACK: sample sda on the 9th rising edge.
  - 0 (ACK): on the SCL fall, pulse rd_req and go to RD_LOAD.
  - 1 (NACK): go to IGNORE, busy=0.
- IGNORE: sda released; wait for START or STOP.
- A partial byte cut off by STOP or START is discarded: no wr_tick.
- Simultaneous SCL and SDA edges in the same filtered clk: treat as data, not as START/STOP.
- Bit counter is 4 bits, counting 0..8.
- Mid-transfer reset releases sda asynchronously within the same clk.

Decomposition:
- Package i2c_pkg holds:
  - the FSM state enum typedef;
  - ACK=1'b0 and NACK=1'b1 constants;
  - the command encodings already used by the master, shared for benches.
- Sub-module i2c_line_filter (2-flop sync + FILTER_LEN counter filter, registered output and rise/fall pulses) is instantiated twice, for scl and sda.
- i2c_slave holds the FSM, shift registers and open-drain sda drive.

Test Plan:
- Write: i2c_master (dvsr=250, 100 MHz) sends START, 8'h54, 8'h55, STOP.
  - Expect sda=0 at the 9th SCL high of the address byte, wr_tick once with wr_data=8'h55, ACK on the data byte, one stop_tick, busy 1 then 0.
- Address miss: START, 8'h60, 8'h12, STOP.
  - Expect sda high at the 9th bit, no wr_tick, busy stays 0, stop_tick=1.
- Read: START, 8'h55, tx_data=8'hA5 after rd_req, master reads with NACK, STOP.
  - Expect master dout=8'hA5, exactly one rd_req, and sda released after NACK.
- Repeated start: write 8'h54 + 8'h3C, RESTART, 8'h55, read two bytes (ACK then NACK) with tx_data 8'h11 then 8'h22.
  - Expect wr_data=8'h3C, reads 8'h11/8'h22, two rd_req.
- Assert reset_n low while sda is driven low during ADDR_ACK.
  - Expect sda=z immediately, all outputs 0, and the next START is handled normally.
- Inject a 2-clk SCL low glitch (FILTER_LEN=4) mid-byte.
  - Expect no extra bit sampled and the byte received intact.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK bus levels and the
// command encodings used by i2c_master.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_LOAD,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WR      = 3'b001;
    localparam logic [2:0] CMD_RD      = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

endpackage

// File: rtl/i2c_line_filter.sv
// 2-flop synchronizer followed by a FILTER_LEN-sample glitch filter; the
// filtered level and its rise/fall pulses are all registered.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_level;
    logic       r_rise;
    logic       r_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Any sample agreeing with the current level restarts the run.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == 4'(FILTER_LEN - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
                r_fall  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with fixed 7-bit address: oversampled START/STOP detection,
// write-byte hand-off, read-byte shift-out, open-drain SDA, no clock stretching.
module i2c_slave import i2c_pkg::*; #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h2A,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  logic       sda,
    output logic       wr_tick,
    output logic [7:0] wr_data,
    output logic       rd_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       stop_tick
);

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_byte;

    state_t     r_state;
    logic [7:0] r_shift;
    logic [3:0] r_cnt;
    logic       r_sda_low;
    logic       r_rw;
    logic       r_busy;
    logic       r_wr_tick;
    logic [7:0] r_wr_data;
    logic       r_rd_req;
    logic       r_stop_tick;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .reset_n(reset_n), .i_line(scl),
        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .reset_n(reset_n), .i_line(sda),
        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    // An SDA edge coinciding with an SCL edge is data, never START/STOP.
    assign w_start = w_sda_fall & w_scl & ~(w_scl_rise | w_scl_fall);
    assign w_stop  = w_sda_rise & w_scl & ~(w_scl_rise | w_scl_fall);
    assign w_byte  = {r_shift[6:0], w_sda};

    assign sda = r_sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_sda_low   <= 1'b0;
            r_rw        <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_tick   <= 1'b0;
            r_wr_data   <= '0;
            r_rd_req    <= 1'b0;
            r_stop_tick <= 1'b0;
        end else begin
            r_wr_tick   <= 1'b0;
            r_rd_req    <= 1'b0;
            r_stop_tick <= 1'b0;
            if (w_stop) begin
                r_state     <= IDLE;
                r_sda_low   <= 1'b0;
                r_busy      <= 1'b0;
                r_stop_tick <= 1'b1;
            end else if (w_start) begin
                r_state   <= ADDR;
                r_cnt     <= '0;
                r_sda_low <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_cnt == 4'd7) begin
                                r_cnt <= 4'd8;
                                r_rw  <= w_sda;
                                if (w_byte[7:1] != SLAVE_ADDR) r_state <= IGNORE;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else if (w_scl_fall && r_cnt == 4'd8) begin
                            r_sda_low <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (r_rw) begin
                                r_rd_req <= 1'b1;
                                r_state  <= RD_LOAD;
                            end else begin
                                r_sda_low <= 1'b0;
                                r_cnt     <= '0;
                                r_state   <= WR_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift <= w_byte;
                            if (r_cnt == 4'd7) begin
                                r_cnt     <= 4'd8;
                                r_wr_data <= w_byte;
                                r_wr_tick <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else if (w_scl_fall && r_cnt == 4'd8) begin
                            r_sda_low <= 1'b1;
                            r_state   <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_low <= 1'b0;
                            r_cnt     <= '0;
                            r_state   <= WR_BYTE;
                        end
                    end
                    RD_LOAD: begin
                        r_shift   <= tx_data;
                        r_sda_low <= ~tx_data[7];
                        r_cnt     <= '0;
                        r_state   <= RD_BYTE;
                    end
                    RD_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_cnt == 4'd7) begin
                                r_sda_low <= 1'b0;
                                r_state   <= RD_ACK;
                            end else begin
                                r_cnt     <= r_cnt + 4'd1;
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_sda_low <= ~r_shift[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (w_scl_rise && w_sda == NACK) begin
                            r_state <= IGNORE;
                            r_busy  <= 1'b0;
                        end else if (w_scl_fall) begin
                            r_rd_req <= 1'b1;
                            r_state  <= RD_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_tick   = r_wr_tick;
    assign wr_data   = r_wr_data;
    assign rd_req    = r_rd_req;
    assign busy      = r_busy;
    assign stop_tick = r_stop_tick;

endmodule
